// File: rtl/crc24_frame_ctrl.sv
// Byte-stream CRC-32 sequencer: packs bytes into 24-bit words for a parallel engine,
// finishes 1-2 tail bytes bit-serially. Option macro: CRC24_CTRL_FINAL_XOR_EN (inverted result).

module crc_d24 (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [23:0] data,
  output logic [31:0] crc_out
);
  localparam logic [31:0] POLY = 32'h04C11DB7;

  logic [31:0] crc_q;
  logic [31:0] crc_d;

  function automatic logic [31:0] crc24_step(input logic [31:0] c, input logic [23:0] d);
    logic [31:0] r;
    logic        fb;
    r = c;
    for (int i = 23; i >= 0; i--) begin
      fb = r[31] ^ d[i];
      r  = {r[30:0], 1'b0} ^ ({32{fb}} & POLY);
    end
    return r;
  endfunction

  always_comb begin
    crc_d = crc_q;
    if (en) begin
      crc_d = crc24_step(crc_q, data);
    end else begin
      crc_d = crc_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) crc_q <= 32'hFFFFFFFF;
    else     crc_q <= crc_d;
  end

  assign crc_out = crc_q;
endmodule

module crc24_frame_ctrl #(
  parameter int LEN_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [7:0]       in_data,
  input  logic             in_valid,
  input  logic             in_sop,
  input  logic             in_eop,
  output logic             in_ready,
  output logic [31:0]      res_crc,
  output logic [LEN_W-1:0] res_len,
  output logic             res_valid,
  input  logic             res_ready,
  output logic             busy
);
  localparam logic [31:0]      POLY    = 32'h04C11DB7;
  localparam logic [LEN_W-1:0] CNT_ONE = {{(LEN_W-1){1'b0}}, 1'b1};
  localparam logic [LEN_W-1:0] CNT_MAX = {LEN_W{1'b1}};

  typedef enum logic [2:0] {S_IDLE, S_ACC, S_FLUSH, S_TAIL, S_DONE} state_t;

  state_t             state_q, state_d;
  logic               in_ready_q, in_ready_d;
  logic               res_valid_q, res_valid_d;
  logic [LEN_W-1:0]   res_len_q, res_len_d;
  logic               busy_q, busy_d;
  logic [LEN_W-1:0]   count_q, count_d;
  logic [1:0]         pos_q, pos_d;
  logic [15:0]        word_q, word_d;
  logic [23:0]        eng_word_q, eng_word_d;
  logic               eng_en_q, eng_en_d;
  logic               eng_rst_q, eng_rst_d;
  logic [1:0]         n_q, n_d;
  logic [31:0]        tail_crc_q, tail_crc_d;
  logic [15:0]        tail_dat_q, tail_dat_d;
  logic [3:0]         tail_cnt_q, tail_cnt_d;
  logic               accept_s;
  logic               fb_s;
  logic [31:0]        crc_out_s;
  logic [31:0]        res_crc_s;

  function automatic logic [31:0] crc_final(input logic [31:0] c);
`ifdef CRC24_CTRL_FINAL_XOR_EN
    return ~c;
`else
    return c;
`endif
  endfunction

  crc_d24 u_crc (
    .clk     (clk),
    .rst     (eng_rst_q),
    .en      (eng_en_q),
    .data    (eng_word_q),
    .crc_out (crc_out_s)
  );

  assign accept_s = in_valid & in_ready_q;
  assign fb_s     = tail_crc_q[31] ^ tail_dat_q[15];

  always_comb begin
    state_d     = state_q;
    in_ready_d  = in_ready_q;
    res_valid_d = res_valid_q;
    res_len_d   = res_len_q;
    busy_d      = busy_q;
    count_d     = count_q;
    pos_d       = pos_q;
    word_d      = word_q;
    eng_word_d  = eng_word_q;
    eng_en_d    = 1'b0;
    eng_rst_d   = 1'b0;
    n_d         = n_q;
    tail_crc_d  = tail_crc_q;
    tail_dat_d  = tail_dat_q;
    tail_cnt_d  = tail_cnt_q;
    case (state_q)
      S_IDLE, S_ACC: begin
        // Outside a frame only SOP bytes matter; SOP inside a frame restarts it.
        if (accept_s && (in_sop || state_q == S_ACC)) begin
          if (in_sop) begin
            eng_rst_d = 1'b1;
            count_d   = CNT_ONE;
            word_d    = {in_data, 8'h00};
            pos_d     = 2'd1;
          end else begin
            count_d = (count_q != CNT_MAX) ? count_q + CNT_ONE : count_q;
            case (pos_q)
              2'd0: begin word_d = {in_data, 8'h00}; pos_d = 2'd1; end
              2'd1: begin word_d = {word_q[15:8], in_data}; pos_d = 2'd2; end
              2'd2: begin
                eng_word_d = {word_q, in_data};
                eng_en_d   = 1'b1;
                word_d     = 16'h0000;
                pos_d      = 2'd0;
              end
              default: pos_d = 2'd0;
            endcase
          end
          busy_d = 1'b1;
          if (in_eop) begin
            state_d    = S_FLUSH;
            in_ready_d = 1'b0;
            n_d        = pos_d;
          end else begin
            state_d = S_ACC;
          end
        end else begin
          state_d = state_q;
        end
      end
      S_FLUSH: begin
        if (n_q == 2'd0) begin
          state_d     = S_DONE;
          res_valid_d = 1'b1;
          res_len_d   = count_q;
        end else begin
          state_d    = S_TAIL;
          tail_crc_d = crc_out_s;
          tail_dat_d = word_q;
          tail_cnt_d = (n_q == 2'd1) ? 4'd7 : 4'd15;
        end
      end
      S_TAIL: begin
        tail_crc_d = {tail_crc_q[30:0], 1'b0} ^ ({32{fb_s}} & POLY);
        tail_dat_d = {tail_dat_q[14:0], 1'b0};
        tail_cnt_d = tail_cnt_q - 4'd1;
        if (tail_cnt_q == 4'd0) begin
          state_d     = S_DONE;
          res_valid_d = 1'b1;
          res_len_d   = count_q;
        end else begin
          state_d = S_TAIL;
        end
      end
      S_DONE: begin
        if (res_ready) begin
          state_d     = S_IDLE;
          res_valid_d = 1'b0;
          res_len_d   = {LEN_W{1'b0}};
          in_ready_d  = 1'b1;
          busy_d      = 1'b0;
        end else begin
          state_d = S_DONE;
        end
      end
      default: begin
        state_d     = S_IDLE;
        in_ready_d  = 1'b1;
        res_valid_d = 1'b0;
        busy_d      = 1'b0;
      end
    endcase
  end

  always_comb begin
    res_crc_s = 32'h00000000;
    if (state_q == S_DONE) begin
      res_crc_s = crc_final((n_q == 2'd0) ? crc_out_s : tail_crc_q);
    end else begin
      res_crc_s = 32'h00000000;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      in_ready_q  <= 1'b1;
      res_valid_q <= 1'b0;
      res_len_q   <= {LEN_W{1'b0}};
      busy_q      <= 1'b0;
      count_q     <= {LEN_W{1'b0}};
      pos_q       <= 2'd0;
      word_q      <= 16'h0000;
      eng_word_q  <= 24'h000000;
      eng_en_q    <= 1'b0;
      eng_rst_q   <= 1'b1;
      n_q         <= 2'd0;
      tail_crc_q  <= 32'h00000000;
      tail_dat_q  <= 16'h0000;
      tail_cnt_q  <= 4'd0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= in_ready_d;
      res_valid_q <= res_valid_d;
      res_len_q   <= res_len_d;
      busy_q      <= busy_d;
      count_q     <= count_d;
      pos_q       <= pos_d;
      word_q      <= word_d;
      eng_word_q  <= eng_word_d;
      eng_en_q    <= eng_en_d;
      eng_rst_q   <= eng_rst_d;
      n_q         <= n_d;
      tail_crc_q  <= tail_crc_d;
      tail_dat_q  <= tail_dat_d;
      tail_cnt_q  <= tail_cnt_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign res_valid = res_valid_q;
  assign res_len   = res_len_q;
  assign busy      = busy_q;
  assign res_crc   = res_crc_s;
endmodule

// File: tb/tb_crc24_frame_ctrl.sv
// Scoreboard bench for crc24_frame_ctrl: a byte-level frame model pushes expected results,
// a monitor pops and compares them when res_valid rises. Small LEN_W to reach saturation.

module tb_crc24_frame_ctrl;
  localparam int          LW   = 4;
  localparam logic [31:0] POLY = 32'h04C11DB7;
  localparam int          LMAX = (1 << LW) - 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [7:0]    in_data = 8'h00;
  logic          in_valid = 1'b0;
  logic          in_sop = 1'b0;
  logic          in_eop = 1'b0;
  logic          in_ready;
  logic [31:0]   res_crc;
  logic [LW-1:0] res_len;
  logic          res_valid;
  logic          res_ready = 1'b0;
  logic          busy;

  crc24_frame_ctrl #(.LEN_W(LW)) dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
    .in_sop(in_sop), .in_eop(in_eop), .in_ready(in_ready), .res_crc(res_crc),
    .res_len(res_len), .res_valid(res_valid), .res_ready(res_ready), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] crc;
    int          len;
    int          due;
  } exp_t;

  exp_t        sbq[$];
  logic [7:0]  frm[$];
  bit          in_frame = 1'b0;
  bit          hold_rr  = 1'b0;
  bit          seen     = 1'b0;
  exp_t        cur;
  int          total = 0;
  int          bad   = 0;
  int          cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #2;
    res_ready = hold_rr ? 1'b0 : ($urandom_range(0, 3) != 0);
  end

  function automatic logic [31:0] fin(input logic [31:0] c);
`ifdef CRC24_CTRL_FINAL_XOR_EN
    return ~c;
`else
    return c;
`endif
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h, want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference frame rules: SOP opens/restarts, non-SOP outside a frame dropped, EOP closes.
  task automatic model_byte(input logic [7:0] d, input bit s, input bit e, input int edge_no);
    logic [31:0] c;
    exp_t        x;
    if (s) begin
      frm.delete();
      in_frame = 1'b1;
    end
    if (in_frame) frm.push_back(d);
    if (e && in_frame) begin
      c = 32'hFFFFFFFF;
      foreach (frm[i]) begin
        for (int b = 7; b >= 0; b--) begin
          c = (c[31] ^ frm[i][b]) ? ((c << 1) ^ POLY) : (c << 1);
        end
      end
      x.crc = fin(c);
      x.len = (frm.size() > LMAX) ? LMAX : frm.size();
      x.due = edge_no + 1 + 8 * (frm.size() % 3);
      sbq.push_back(x);
      in_frame = 1'b0;
    end
  endtask

  always @(negedge clk) begin
    if (res_valid) begin
      if (!seen) begin
        if (sbq.size() == 0) begin
          check("unexpected_result", res_crc, 32'hxxxxxxxx);
        end else begin
          cur = sbq.pop_front();
          check("res_crc", res_crc, cur.crc);
          check("res_len", {{(32-LW){1'b0}}, res_len}, cur.len);
          check("latency_edge", cyc, cur.due);
        end
        seen = 1'b1;
      end else begin
        check("res_crc_stable", res_crc, cur.crc);
        check("res_len_stable", {{(32-LW){1'b0}}, res_len}, cur.len);
      end
      check("in_ready_in_done", {31'd0, in_ready}, 32'd0);
      if (res_ready) seen = 1'b0;
    end else begin
      seen = 1'b0;
    end
  end

  task automatic send_byte(input logic [7:0] d, input bit s, input bit e);
    int k;
    in_data = d; in_sop = s; in_eop = e; in_valid = 1'b1;
    for (k = 0; k < 2000 && !in_ready; k++) @(negedge clk);
    if (!in_ready) begin
      check("in_ready_timeout", {31'd0, in_ready}, 32'd1);
    end else begin
      model_byte(d, s, e, cyc + 1);
      @(negedge clk);
    end
    in_valid = 1'b0; in_sop = 1'b0; in_eop = 1'b0;
  endtask

  task automatic send_str(input string s, input bit gaps);
    for (int i = 0; i < s.len(); i++) begin
      send_byte(s[i], i == 0, i == s.len() - 1);
      if (gaps) repeat ($urandom_range(0, 2)) @(negedge clk);
    end
  endtask

  task automatic drain();
    int k;
    for (k = 0; k < 600 && (sbq.size() != 0 || res_valid); k++) @(negedge clk);
    if (sbq.size() != 0 || res_valid) check("drain_timeout", sbq.size(), 32'd0);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_in_ready"}, {31'd0, in_ready}, 32'd1);
    check({tag, "_res_valid"}, {31'd0, res_valid}, 32'd0);
    check({tag, "_res_crc"}, res_crc, 32'd0);
    check({tag, "_res_len"}, {{(32-LW){1'b0}}, res_len}, 32'd0);
    check({tag, "_busy"}, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    int k;
    logic [31:0] k9;
`ifdef CRC24_CTRL_FINAL_XOR_EN
    k9 = 32'hFC891918;
`else
    k9 = 32'h0376E6E7;
`endif
    repeat (2) @(negedge clk);
    check_reset_vals("reset");
    rst_n = 1'b1;
    @(negedge clk);

    send_str("123456789", 1'b0);
    sbq[sbq.size() - 1].crc = k9;
    drain();

    send_str("1234567890", 1'b0);
    for (k = 0; k < 40 && !res_valid; k++) begin
      check("in_ready_low_tail", {31'd0, in_ready}, 32'd0);
      check("busy_high_tail", {31'd0, busy}, 32'd1);
      @(negedge clk);
    end
    drain();

    send_byte(8'h00, 1'b1, 1'b1);
    drain();

    send_str("1234", 1'b0);
    send_str("123456789", 1'b1);
    sbq[sbq.size() - 1].crc = k9;
    drain();

    hold_rr = 1'b1;
    send_str("ab", 1'b0);
    for (k = 0; k < 40 && !res_valid; k++) @(negedge clk);
    in_data = 8'h31; in_sop = 1'b1; in_eop = 1'b0; in_valid = 1'b1;
    repeat (20) begin
      @(negedge clk);
      check("stall_in_ready", {31'd0, in_ready}, 32'd0);
      check("stall_res_valid", {31'd0, res_valid}, 32'd1);
    end
    hold_rr = 1'b0;
    send_str("123456789", 1'b0);
    drain();

    send_str("1234567890", 1'b0);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check_reset_vals("tail_reset");
    rst_n = 1'b1;
    void'(sbq.pop_back());
    in_frame = 1'b0;
    @(negedge clk);
    send_str("123456789", 1'b0);
    sbq[sbq.size() - 1].crc = k9;
    drain();

    for (int f = 0; f < 30; f++) begin
      int len;
      repeat ($urandom_range(0, 2)) send_byte(8'($urandom), 1'b0, ($urandom_range(0, 3) == 0));
      if ($urandom_range(0, 4) == 0) begin
        repeat ($urandom_range(1, 5)) send_byte(8'($urandom), 1'b0, 1'b0);
        frm.delete();
        send_byte(8'($urandom), 1'b1, 1'b0);
        repeat ($urandom_range(0, 4)) send_byte(8'($urandom), 1'b0, 1'b0);
      end
      len = $urandom_range(1, 20);
      for (int i = 0; i < len; i++) begin
        send_byte(8'($urandom), i == 0, i == len - 1);
        repeat ($urandom_range(0, 1)) @(negedge clk);
      end
    end
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
